// File: rtl/load_store_unit.sv
// Load/store unit: data-memory handshake, store lane steering and load extension.
// Holds the core in stall from request issue until the access completes.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  store,
  input  logic [2:0]            func_3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           store_data,
  output logic [31:0]           load_data,
  output logic                  stall,
  output logic                  fault,
  output logic                  mem_request,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic [3:0]            mem_byte_enable,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                state_q, state_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  mem_request_q, mem_request_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [31:0]           mem_write_data_q, mem_write_data_d;
  logic [3:0]            mem_byte_enable_q, mem_byte_enable_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic [2:0]            func_3_q, func_3_d;

  logic        legal_f3, misaligned, access_err, start;
  logic [31:0] wdata, lane, ext;
  logic [3:0]  be;

  // Request decode and fault detection; only meaningful while idle
  always_comb begin
    legal_f3 = 1'b0;
    if (load)  legal_f3 = (func_3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (store) legal_f3 = (func_3 inside {3'b000, 3'b001, 3'b010});
    misaligned = ((func_3[1:0] == 2'b01) && address[0]) ||
                 ((func_3[1:0] == 2'b10) && (address[1:0] != 2'b00));
    access_err = (load & store) | ((load ^ store) & (~legal_f3 | misaligned));
    start      = (state_q == IDLE) && (load ^ store) && !access_err;
    fault      = (state_q == IDLE) && access_err;
    stall      = start || (state_q == ACCESS);
  end

  // Store lane replication and byte enables; loads always read the full word
  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    if (store) begin
      case (func_3[1:0])
        2'b00: begin
          wdata = {4{store_data[7:0]}};
          be    = 4'(4'b0001 << address[1:0]);
        end
        2'b01: begin
          wdata = {2{store_data[15:0]}};
          be    = address[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata = store_data;
          be    = 4'b1111;
        end
      endcase
    end
  end

  // Load lane select and sign/zero extension from the latched access
  always_comb begin
    lane = mem_read_data >> {addr_lo_q, 3'b000};
    case (func_3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = mem_read_data;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    load_data_d       = load_data_q;
    mem_request_d     = mem_request_q;
    mem_write_d       = mem_write_q;
    mem_address_d     = mem_address_q;
    mem_write_data_d  = mem_write_data_q;
    mem_byte_enable_d = mem_byte_enable_q;
    addr_lo_d         = addr_lo_q;
    func_3_d          = func_3_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d           = ACCESS;
          mem_request_d     = 1'b1;
          mem_write_d       = store;
          mem_address_d     = {address[ADDR_WIDTH-1:2], 2'b00};
          mem_write_data_d  = wdata;
          mem_byte_enable_d = be;
          addr_lo_d         = address[1:0];
          func_3_d          = func_3;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d       = DONE;
          mem_request_d = 1'b0;
          if (!mem_write_q) load_data_d = ext;
        end
      end
      // Retiring instruction still presents load/store here; never restart from DONE
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      load_data_q       <= '0;
      mem_request_q     <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= '0;
      mem_write_data_q  <= '0;
      mem_byte_enable_q <= '0;
      addr_lo_q         <= '0;
      func_3_q          <= '0;
    end else begin
      state_q           <= state_d;
      load_data_q       <= load_data_d;
      mem_request_q     <= mem_request_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_write_data_q  <= mem_write_data_d;
      mem_byte_enable_q <= mem_byte_enable_d;
      addr_lo_q         <= addr_lo_d;
      func_3_q          <= func_3_d;
    end
  end

  assign load_data       = load_data_q;
  assign mem_request     = mem_request_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_write_data  = mem_write_data_q;
  assign mem_byte_enable = mem_byte_enable_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan accesses plus
// randomized accesses checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load, store;
  logic [2:0]  func_3;
  logic [31:0] address, store_data;
  logic [31:0] load_data;
  logic        stall, fault;
  logic        mem_request, mem_write;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_ready;
  logic [31:0] mem_read_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_req    = 0;
  int exp_req  = 0;
  logic        req_prev = 1'b0;
  logic [31:0] exp_ld = '0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .func_3(func_3),
    .address(address), .store_data(store_data), .load_data(load_data),
    .stall(stall), .fault(fault), .mem_request(mem_request),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_ready(mem_ready), .mem_read_data(mem_read_data)
  );

  // Count distinct bus requests (rising edges of mem_request)
  always @(negedge clk) begin
    if (mem_request && !req_prev) n_req <= n_req + 1;
    req_prev <= mem_request;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: a legal access has a known size in bytes and must be size-aligned
  function automatic bit model_fault(bit ld, bit st, logic [2:0] f3, logic [31:0] a);
    int sz;
    if (ld && st) return 1'b1;
    if (!ld && !st) return 1'b0;
    if (st && f3 > 3'd2) return 1'b1;
    if (ld && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    sz = 1 << int'(f3[1:0]);
    return (int'(a[1:0]) % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    int unsigned v;
    int unsigned off;
    off = int'(a[1:0]) * 8;
    v = w;
    case (f3)
      3'd0: begin v = (w >> off) % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = (w >> off) % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd4: v = (w >> off) % 256;
      3'd5: v = (w >> off) % 65536;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
    if (f3 == 3'd0) return (d % 256) * 32'h0101_0101;
    if (f3 == 3'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] model_be(bit st, logic [2:0] f3, logic [31:0] a);
    if (!st || f3 == 3'd2) return 4'b1111;
    if (f3 == 3'd0) return 4'(1 << int'(a[1:0]));
    return 4'(3 << int'(a[1:0]));
  endfunction

  // One instruction: drive in IDLE, service the bus with `waits` not-ready cycles, check DONE
  task automatic do_access(input bit ld, input bit st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int waits);
    bit exp_fault;
    int stall_cnt;
    exp_fault = model_fault(ld, st, f3, a);
    @(negedge clk);
    load = ld; store = st; func_3 = f3; address = a; store_data = sd;
    mem_ready = 1'($urandom_range(0, 1)); mem_read_data = $urandom;
    #1;
    check("fault_idle", 32'(fault), 32'(exp_fault));
    check("stall_idle", 32'(stall), 32'((ld ^ st) && !exp_fault));
    if (exp_fault || !(ld ^ st)) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk); #1;
        check("noreq_req", 32'(mem_request), 32'd0);
        check("noreq_stall", 32'(stall), 32'd0);
      end
      check("noreq_load_data", load_data, exp_ld);
      check("noreq_count", 32'(n_req), 32'(exp_req));
      return;
    end
    stall_cnt = 1;
    mem_ready = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk); #1;
      check("acc_req", 32'(mem_request), 32'd1);
      check("acc_addr", mem_address, {a[31:2], 2'b00});
      check("acc_be", 32'(mem_byte_enable), 32'(model_be(st, f3, a)));
      check("acc_write", 32'(mem_write), 32'(st));
      if (st) check("acc_wdata", mem_write_data, model_wdata(f3, sd));
      if (stall) stall_cnt++;
      mem_ready = (w == waits);
      mem_read_data = (w == waits) ? rd : $urandom;
    end
    exp_req++;
    if (ld) exp_ld = model_load(f3, a, rd);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("done_stall", 32'(stall), 32'd0);
    check("done_req", 32'(mem_request), 32'd0);
    check("done_fault", 32'(fault), 32'd0);
    check("done_load_data", load_data, exp_ld);
    check("stall_cycles", 32'(stall_cnt), 32'(waits + 2));
    check("req_count", 32'(n_req), 32'(exp_req));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; store = 1'b0; func_3 = '0; address = '0;
    store_data = '0; mem_ready = 1'b0; mem_read_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_load_data", load_data, 32'd0);
    check("rst_req", 32'(mem_request), 32'd0);
    check("rst_addr", mem_address, 32'd0);
    check("rst_be", 32'(mem_byte_enable), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    rst = 1'b0;

    // Aligned loads and halfword lanes
    do_access(1, 0, 3'd2, 32'h100, 32'h0, 32'h8000_00F0, 0);
    check("lw_value", load_data, 32'h8000_00F0);
    do_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h8000_00F0, 0);
    check("lb_value", load_data, 32'hFFFF_FF80);
    do_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h8000_00F0, 0);
    check("lbu_value", load_data, 32'h0000_0080);
    do_access(1, 0, 3'd1, 32'h102, 32'h0, 32'h8000_00F0, 0);
    check("lh_value", load_data, 32'hFFFF_8000);
    do_access(1, 0, 3'd5, 32'h100, 32'h0, 32'h8000_00F0, 0);
    check("lhu_value", load_data, 32'h0000_00F0);

    // Stores leave load_data alone
    do_access(0, 1, 3'd0, 32'h201, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
    check("sb_wdata", mem_write_data, 32'hCDCD_CDCD);
    do_access(0, 1, 3'd1, 32'h202, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
    check("sh_be", 32'(mem_byte_enable), 32'h0000_000C);
    do_access(0, 1, 3'd2, 32'h200, 32'h1234_ABCD, 32'hDEAD_BEEF, 0);
    check("store_keeps_load_data", load_data, 32'h0000_00F0);

    // Wait states and faults
    do_access(1, 0, 3'd2, 32'h104, 32'h0, 32'hA5A5_0001, 4);
    do_access(1, 0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    do_access(0, 1, 3'd1, 32'h301, 32'h0, 32'h0, 0);
    do_access(1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
    do_access(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0);

    // Reset in the second ACCESS cycle
    @(negedge clk);
    load = 1'b1; store = 1'b0; func_3 = 3'd2; address = 32'h400; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    exp_req++;
    rst = 1'b1; load = 1'b0; mem_ready = 1'b1; mem_read_data = 32'h1111_2222;
    #1;
    check("midrst_req", 32'(mem_request), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_load_data", load_data, 32'd0);
    check("midrst_addr", mem_address, 32'd0);
    check("midrst_wdata", mem_write_data, 32'd0);
    check("midrst_write", 32'(mem_write), 32'd0);
    exp_ld = '0;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;

    // Back-to-back loads with load held high across DONE
    do_access(1, 0, 3'd2, 32'h500, 32'h0, 32'h0BAD_F00D, 0);
    do_access(1, 0, 3'd2, 32'h504, 32'h0, 32'h600D_CAFE, 1);
    @(negedge clk);
    load = 1'b0; #1;
    check("b2b_load_data", load_data, 32'h600D_CAFE);

    // Randomized accesses, biased toward legal ones
    for (int k = 0; k < 60; k++) begin
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 5) == 0) ? ld : !ld;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
         : (st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'd4 : 3'd0));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a = (f3[1:0] == 2'd2) ? {a[31:2], 2'b00}
                                       : (f3[1:0] == 2'd1) ? {a[31:1], 1'b0} : a;
      do_access(ld, st, f3, a, $urandom, $urandom, $urandom_range(0, 3));
    end
    @(negedge clk);
    load = 1'b0; store = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
